// File: rtl/bus_store_master_if.sv
// Store-path bundle between a core store port, the store-bus arbiter and an AXI slave.
// The master modport belongs to bus_store_master; the slave modport is for everything it talks to.
interface bus_store_master_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              st_req;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic [STRB_W-1:0] st_strb;
  logic [2:0]        st_size;
  logic              st_ready;
  logic              st_done;
  logic              st_err;
  logic              bus_busy;
  logic              bus_req;
  logic              bus_grnt;

  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;

  logic [ID_W-1:0]   wid;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    input  st_req, st_addr, st_data, st_strb, st_size, bus_grnt,
           awready, wready, bid, bresp, bvalid,
    output st_ready, st_done, st_err, bus_busy, bus_req,
           awid, awaddr, awlen, awsize, awburst, awvalid,
           wid, wdata, wstrb, wlast, wvalid, bready
  );

  modport slave (
    output st_req, st_addr, st_data, st_strb, st_size, bus_grnt,
           awready, wready, bid, bresp, bvalid,
    input  st_ready, st_done, st_err, bus_busy, bus_req,
           awid, awaddr, awlen, awsize, awburst, awvalid,
           wid, wdata, wstrb, wlast, wvalid, bready
  );
endinterface

// File: rtl/bus_store_master.sv
// Single-beat AXI store master: takes one store from the core, wins the store-bus
// arbiter, then runs AW/W/B to completion and reports the write response.
module bus_store_master #(
  parameter int              ID_W   = 4,
  parameter logic [ID_W-1:0] AXI_ID = 4'd0,
  parameter int              ADDR_W = 32,
  parameter int              DATA_W = 32
) (
  input logic               clk,
  input logic               rst_n,
  bus_store_master_if.master bus
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, REQ, XFER, RESP} state_t;

  state_t            state, state_nxt;
  logic              aw_pend, aw_pend_nxt;
  logic              w_pend, w_pend_nxt;
  logic              aw_fin, w_fin;
  logic              accept;
  logic              done_nxt, err_nxt;
  logic              st_done_q, st_err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [STRB_W-1:0] strb_q;
  logic [2:0]        size_q;
  logic              unused_bid;

  // A channel counts as finished once its valid has gone or is being accepted now
  assign aw_fin = !aw_pend || bus.awready;
  assign w_fin  = !w_pend  || bus.wready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      aw_pend   <= 1'b0;
      w_pend    <= 1'b0;
      st_done_q <= 1'b0;
      st_err_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      size_q    <= '0;
    end else begin
      state     <= state_nxt;
      aw_pend   <= aw_pend_nxt;
      w_pend    <= w_pend_nxt;
      st_done_q <= done_nxt;
      st_err_q  <= err_nxt;
      if (accept) begin
        addr_q <= bus.st_addr;
        data_q <= bus.st_data;
        strb_q <= bus.st_strb;
        size_q <= bus.st_size;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    aw_pend_nxt = aw_pend;
    w_pend_nxt  = w_pend;
    accept      = 1'b0;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.st_req) begin
          accept    = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (bus.bus_grnt) begin
          aw_pend_nxt = 1'b1;
          w_pend_nxt  = 1'b1;
          state_nxt   = XFER;
        end
      end
      XFER: begin
        // Grant loss here is deliberately ignored; the transaction runs to completion
        if (aw_pend && bus.awready) aw_pend_nxt = 1'b0;
        if (w_pend && bus.wready)   w_pend_nxt  = 1'b0;
        if (aw_fin && w_fin)        state_nxt   = RESP;
      end
      RESP: begin
        if (bus.bvalid) begin
          done_nxt  = 1'b1;
          err_nxt   = (bus.bresp != 2'b00);
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // bus_req stays up through XFER/RESP so a preferred-master arbiter keeps us owning the bus
  assign bus.st_ready = (state == IDLE);
  assign bus.st_done  = st_done_q;
  assign bus.st_err   = st_err_q;
  assign bus.bus_req  = (state != IDLE);
  assign bus.bus_busy = (state == XFER) || (state == RESP);
  assign bus.bready   = (state == RESP);

  assign bus.awid    = AXI_ID;
  assign bus.awaddr  = addr_q;
  assign bus.awlen   = 8'd0;
  assign bus.awsize  = size_q;
  assign bus.awburst = 2'b01;
  assign bus.awvalid = aw_pend;

  assign bus.wid    = AXI_ID;
  assign bus.wdata  = data_q;
  assign bus.wstrb  = strb_q;
  assign bus.wlast  = 1'b1;
  assign bus.wvalid = w_pend;

  assign unused_bid = ^bus.bid;
endmodule

// File: tb/tb_bus_store_master.sv
// Bench for bus_store_master: a few hand-computed directed stores, then a long run of
// random core/arbiter/slave behaviour checked every cycle against a transaction-level model.
module tb_bus_store_master;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  bus_store_master_if #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) bus ();

  bus_store_master #(
    .ID_W  (4),
    .AXI_ID(4'd0),
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: one outstanding store, tracked by which of its milestones have happened
  logic        m_known;
  logic        m_have;
  logic        m_grant;
  logic        m_aw_done;
  logic        m_w_done;
  logic        m_done;
  logic        m_err;
  logic [31:0] m_addr;
  logic [31:0] m_data;
  logic [3:0]  m_strb;
  logic [2:0]  m_size;

  initial m_known = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_known   <= 1'b1;
      m_have    <= 1'b0;
      m_grant   <= 1'b0;
      m_aw_done <= 1'b0;
      m_w_done  <= 1'b0;
      m_done    <= 1'b0;
      m_err     <= 1'b0;
      m_addr    <= '0;
      m_data    <= '0;
      m_strb    <= '0;
      m_size    <= '0;
    end else begin
      m_done <= 1'b0;
      m_err  <= 1'b0;
      if (!m_have) begin
        if (bus.st_req) begin
          m_have  <= 1'b1;
          m_grant <= 1'b0;
          m_addr  <= bus.st_addr;
          m_data  <= bus.st_data;
          m_strb  <= bus.st_strb;
          m_size  <= bus.st_size;
        end
      end else if (!m_grant) begin
        if (bus.bus_grnt) begin
          m_grant   <= 1'b1;
          m_aw_done <= 1'b0;
          m_w_done  <= 1'b0;
        end
      end else if (!(m_aw_done && m_w_done)) begin
        if (bus.awready) m_aw_done <= 1'b1;
        if (bus.wready)  m_w_done  <= 1'b1;
      end else if (bus.bvalid) begin
        m_have  <= 1'b0;
        m_grant <= 1'b0;
        m_done  <= 1'b1;
        m_err   <= (bus.bresp != 2'b00);
      end
    end
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Outputs depend only on registered state, so mid-cycle sampling is race-free
  always @(negedge clk) begin
    if (m_known) begin
      check_output("st_ready", 64'(bus.st_ready), 64'(!m_have));
      check_output("bus_req",  64'(bus.bus_req),  64'(m_have));
      check_output("bus_busy", 64'(bus.bus_busy), 64'(m_have && m_grant));
      check_output("awvalid",  64'(bus.awvalid),  64'(m_have && m_grant && !m_aw_done));
      check_output("wvalid",   64'(bus.wvalid),   64'(m_have && m_grant && !m_w_done));
      check_output("bready",   64'(bus.bready),   64'(m_have && m_grant && m_aw_done && m_w_done));
      check_output("st_done",  64'(bus.st_done),  64'(m_done));
      if (m_done) check_output("st_err", 64'(bus.st_err), 64'(m_err));
      check_output("consts", 64'({bus.awid, bus.wid, bus.awlen, bus.awburst, bus.wlast}),
                   64'({4'd0, 4'd0, 8'd0, 2'b01, 1'b1}));
      if (m_have && m_grant && !m_aw_done) begin
        check_output("awaddr", 64'(bus.awaddr), 64'(m_addr));
        check_output("awsize", 64'(bus.awsize), 64'(m_size));
      end
      if (m_have && m_grant && !m_w_done) begin
        check_output("wdata", 64'(bus.wdata), 64'(m_data));
        check_output("wstrb", 64'(bus.wstrb), 64'(m_strb));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_stimulus(input logic req, input logic [31:0] addr, input logic [31:0] data,
                                input logic [3:0] strb, input logic [2:0] size, input logic grnt,
                                input logic awr, input logic wr, input logic bv, input logic [1:0] br);
    bus.st_req   = req;
    bus.st_addr  = addr;
    bus.st_data  = data;
    bus.st_strb  = strb;
    bus.st_size  = size;
    bus.bus_grnt = grnt;
    bus.awready  = awr;
    bus.wready   = wr;
    bus.bvalid   = bv;
    bus.bresp    = br;
    bus.bid      = 4'd0;
  endtask

  logic grant_level;

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    apply_stimulus(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    repeat (3) tick();
    rst_n = 1'b1;
    #3;
    check_output("reset st_ready", 64'(bus.st_ready), 64'd1);
    check_output("reset bus_req",  64'(bus.bus_req),  64'd0);
    check_output("reset awvalid",  64'(bus.awvalid),  64'd0);
    check_output("reset awaddr",   64'(bus.awaddr),   64'd0);

    // Cycle 0: store accepted with grant already held and an always-ready slave
    apply_stimulus(1'b1, 32'h1000, 32'hDEADBEEF, 4'hF, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
    tick();
    apply_stimulus(1'b0, 32'h0, 32'h0, 4'h0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
    tick();
    #3;
    check_output("t1 awvalid c2", 64'(bus.awvalid), 64'd1);
    check_output("t1 wvalid c2",  64'(bus.wvalid),  64'd1);
    check_output("t1 awaddr c2",  64'(bus.awaddr),  64'h1000);
    check_output("t1 wdata c2",   64'(bus.wdata),   64'hDEADBEEF);
    tick();
    #3;
    check_output("t1 bready c3", 64'(bus.bready), 64'd1);
    tick();
    bus.bvalid = 1'b1;
    tick();
    bus.bvalid = 1'b0;
    #3;
    check_output("t1 st_done c5", 64'(bus.st_done), 64'd1);
    check_output("t1 st_err c5",  64'(bus.st_err),  64'd0);
    check_output("t5 st_ready c5", 64'(bus.st_ready), 64'd1);

    // Back-to-back store on the st_done cycle, answered with SLVERR
    apply_stimulus(1'b1, 32'h2004, 32'h12345678, 4'h3, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10);
    tick();
    bus.st_req = 1'b0;
    #3;
    check_output("t5 bus_req", 64'(bus.bus_req), 64'd1);
    repeat (3) tick();
    bus.bvalid = 1'b1;
    tick();
    bus.bvalid = 1'b0;
    #3;
    check_output("t4 st_done", 64'(bus.st_done), 64'd1);
    check_output("t4 st_err",  64'(bus.st_err),  64'd1);

    // Random core/arbiter/slave behaviour; grant comes in runs to exercise long waits
    grant_level = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      if ($urandom_range(0, 4) == 0) grant_level = ~grant_level;
      rst_n = ($urandom_range(0, 299) != 0);
      apply_stimulus(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                     3'($urandom_range(0, 2)), grant_level,
                     ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                     ($urandom_range(0, 1) == 0), 2'($urandom_range(0, 3)));
    end
    tick();
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
